cart_mapper_2600: RTL

- Downstream consumer of the ROM-download/detection stage.
- Latches the detected bank-switch scheme, cart size and Superchip flag when the download completes.
- Translates 6507 cartridge-space accesses into ROM byte addresses and Superchip RAM controls.
- Tracks bank-select hotspot accesses, so ROM address generation follows the cartridge's live bank state.

---
 rtl/cart_mapper_2600.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cart_mapper_2600.sv
// Atari 2600 cartridge mapper: latches the detected scheme and turns 6507 bus cycles into ROM/Superchip controls.
// Define MAPPER_E0_EN to build E0 slice decoding; otherwise scheme 4 falls back to F8.
module cart_mapper_2600 #(
  parameter int ROM_AW = 15,
  parameter int SC_AW  = 7
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_bs,
  input  logic [31:0]       cfg_size,
  input  logic              cfg_sc,
  input  logic              cpu_access,
  input  logic [12:0]       cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_din,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_oe,
  output logic [SC_AW-1:0]  sc_addr,
  output logic              sc_we,
  output logic              sc_oe,
  output logic              configured
);

  typedef enum logic {ST_UNCONF, ST_ACTIVE} state_t;
  typedef enum logic [2:0] {SCH_PLAIN, SCH_F8, SCH_F6, SCH_F4, SCH_E0, SCH_3F} scheme_t;

  state_t            r_state, w_state_n;
  scheme_t           r_bs, w_bs_n, w_cfg_sch;
  logic [7:0]        r_mask, w_mask_n, w_cfg_mask;
  logic              r_small, w_small_n;
  logic              r_sc, w_sc_n;
  logic [7:0]        r_bank0, w_bank0_n;
`ifdef MAPPER_E0_EN
  logic [7:0]        r_e0_s1, w_e0_s1_n;
  logic [7:0]        r_e0_s2, w_e0_s2_n;
`endif
  logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_n, w_full;
  logic              r_rom_oe, w_rom_oe_n;
  logic [SC_AW-1:0]  r_sc_addr, w_sc_addr_n;
  logic              r_sc_we, w_sc_we_n;
  logic              r_sc_oe, w_sc_oe_n;
  logic [7:0]        w_slice;
  logic              w_sc_en, w_sc_wwin, w_sc_rwin, w_sc_hit;
  int unsigned       w_shift;

  // Bank mask = (ceil_pow2(size) / bank_size) - 1, via smearing the top set bit of (size-1) >> shift.
  function automatic logic [7:0] f_mask(input logic [31:0] size, input int unsigned shift);
    logic [31:0] v;
    v = (size == '0) ? '0 : ((size - 32'd1) >> shift);
    for (int unsigned i = 0; i < 5; i++) v = v | (v >> (32'd1 << i));
    return v[7:0];
  endfunction

  always_comb begin
    w_cfg_sch = SCH_PLAIN;
    case (cfg_bs)
      4'd1: w_cfg_sch = SCH_F8;
      4'd2: w_cfg_sch = SCH_F6;
      4'd3: w_cfg_sch = SCH_F4;
      4'd4: begin
`ifdef MAPPER_E0_EN
        w_cfg_sch = SCH_E0;
`else
        w_cfg_sch = SCH_F8;
`endif
      end
      4'd5: w_cfg_sch = SCH_3F;
      default: w_cfg_sch = SCH_PLAIN;
    endcase
    w_shift = 12;
    case (w_cfg_sch)
      SCH_E0:  w_shift = 10;
      SCH_3F:  w_shift = 11;
      default: w_shift = 12;
    endcase
    w_cfg_mask = f_mask(cfg_size, w_shift);
  end

  assign w_sc_en   = r_sc && (r_bs != SCH_3F);
  assign w_sc_wwin = w_sc_en && (cpu_addr[12:7] == 6'b10_0000);
  assign w_sc_rwin = w_sc_en && (cpu_addr[12:7] == 6'b10_0001);
  assign w_sc_hit  = w_sc_wwin || w_sc_rwin;

  always_comb begin
    w_slice = '0;
    w_full  = '0;
    case (r_bs)
      SCH_F8, SCH_F6, SCH_F4: w_full = ROM_AW'({12'b0, r_bank0, cpu_addr[11:0]});
`ifdef MAPPER_E0_EN
      SCH_E0: begin
        case (cpu_addr[11:10])
          2'd0:    w_slice = r_bank0;
          2'd1:    w_slice = r_e0_s1;
          2'd2:    w_slice = r_e0_s2;
          default: w_slice = 8'd7;
        endcase
        w_full = ROM_AW'({14'b0, w_slice, cpu_addr[9:0]});
      end
`endif
      SCH_3F: begin
        w_slice = cpu_addr[11] ? r_mask : r_bank0;
        w_full  = ROM_AW'({13'b0, w_slice, cpu_addr[10:0]});
      end
      default: w_full = r_small ? ROM_AW'({21'b0, cpu_addr[10:0]})
                                : ROM_AW'({20'b0, cpu_addr[11:0]});
    endcase
  end

  always_comb begin
    w_state_n    = r_state;
    w_bs_n       = r_bs;
    w_mask_n     = r_mask;
    w_small_n    = r_small;
    w_sc_n       = r_sc;
    w_bank0_n    = r_bank0;
`ifdef MAPPER_E0_EN
    w_e0_s1_n    = r_e0_s1;
    w_e0_s2_n    = r_e0_s2;
`endif
    w_rom_addr_n = r_rom_addr;
    w_rom_oe_n   = 1'b0;
    w_sc_addr_n  = r_sc_addr;
    w_sc_we_n    = 1'b0;
    w_sc_oe_n    = 1'b0;

    if (r_state == ST_ACTIVE && cpu_access) begin
      // Output mapping uses the bank state before any hotspot update below.
      w_rom_addr_n = w_full;
      w_rom_oe_n   = cpu_addr[12] && !cpu_we && !w_sc_hit;
      w_sc_we_n    = w_sc_wwin && cpu_we;
      w_sc_oe_n    = w_sc_rwin && !cpu_we;
      if (w_sc_hit) w_sc_addr_n = cpu_addr[SC_AW-1:0];
      case (r_bs)
        SCH_F8: if (cpu_addr >= 13'h1FF8 && cpu_addr <= 13'h1FF9)
                  w_bank0_n = 8'(cpu_addr - 13'h1FF8) & r_mask;
        SCH_F6: if (cpu_addr >= 13'h1FF6 && cpu_addr <= 13'h1FF9)
                  w_bank0_n = 8'(cpu_addr - 13'h1FF6) & r_mask;
        SCH_F4: if (cpu_addr >= 13'h1FF4 && cpu_addr <= 13'h1FFB)
                  w_bank0_n = 8'(cpu_addr - 13'h1FF4) & r_mask;
`ifdef MAPPER_E0_EN
        SCH_E0: if (cpu_addr >= 13'h1FE0 && cpu_addr <= 13'h1FF7) begin
                  case (cpu_addr[4:3])
                    2'd0:    w_bank0_n = {5'b0, cpu_addr[2:0]} & r_mask;
                    2'd1:    w_e0_s1_n = {5'b0, cpu_addr[2:0]} & r_mask;
                    default: w_e0_s2_n = {5'b0, cpu_addr[2:0]} & r_mask;
                  endcase
                end
`endif
        SCH_3F: if (cpu_we && !cpu_addr[12] && cpu_addr[7:0] < 8'h40)
                  w_bank0_n = cpu_din & r_mask;
        default: ;
      endcase
    end

    // A configuration load wins over any hotspot seen in the same cycle.
    if (cfg_valid) begin
      w_state_n = ST_ACTIVE;
      w_bs_n    = w_cfg_sch;
      w_mask_n  = w_cfg_mask;
      w_small_n = (cfg_size <= 32'd2048);
      w_sc_n    = cfg_sc;
      case (w_cfg_sch)
        SCH_F8:  w_bank0_n = 8'd1 & w_cfg_mask;
        SCH_F6:  w_bank0_n = 8'd3 & w_cfg_mask;
        SCH_F4:  w_bank0_n = 8'd7 & w_cfg_mask;
        SCH_E0:  w_bank0_n = 8'd4 & w_cfg_mask;
        default: w_bank0_n = '0;
      endcase
`ifdef MAPPER_E0_EN
      w_e0_s1_n = 8'd5 & w_cfg_mask;
      w_e0_s2_n = 8'd6 & w_cfg_mask;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_UNCONF;
      r_bs       <= SCH_PLAIN;
      r_mask     <= '0;
      r_small    <= 1'b0;
      r_sc       <= 1'b0;
      r_bank0    <= '0;
`ifdef MAPPER_E0_EN
      r_e0_s1    <= '0;
      r_e0_s2    <= '0;
`endif
      r_rom_addr <= '0;
      r_rom_oe   <= 1'b0;
      r_sc_addr  <= '0;
      r_sc_we    <= 1'b0;
      r_sc_oe    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_bs       <= w_bs_n;
      r_mask     <= w_mask_n;
      r_small    <= w_small_n;
      r_sc       <= w_sc_n;
      r_bank0    <= w_bank0_n;
`ifdef MAPPER_E0_EN
      r_e0_s1    <= w_e0_s1_n;
      r_e0_s2    <= w_e0_s2_n;
`endif
      r_rom_addr <= w_rom_addr_n;
      r_rom_oe   <= w_rom_oe_n;
      r_sc_addr  <= w_sc_addr_n;
      r_sc_we    <= w_sc_we_n;
      r_sc_oe    <= w_sc_oe_n;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign rom_oe     = r_rom_oe;
  assign sc_addr    = r_sc_addr;
  assign sc_we      = r_sc_we;
  assign sc_oe      = r_sc_oe;
  assign configured = (r_state == ST_ACTIVE);

endmodule
